max_pool_ctrl: RTL
==================

// Module: max_pool_ctrl
// PURPOSE
//  Sequencer for the 3x3 max_pool datapath. Walks one feature map (channel, oy, ox), reads 9 window pixels from the FM buffer, fires the pool unit, and writes each result to the output buffer.
//  Sits between the conv-layer FM memory and the next layer's input memory; layer control starts it and sees done.
// PARAMETERS
//  DATA_W    23   pixel/result width
//  ADDR_W    20   FM and output address width
//  IN_W      55   input map width (pixels)
//  IN_H      55   input map height
//  CHANNELS  96   number of channels pooled
//  STRIDE    2    window stride; legal values 1..3
//  OUT_W/OUT_H are derived: (IN_W-3)/STRIDE+1 and (IN_H-3)/STRIDE+1.
// PORTS
//  clk          in   1          clock
//  rst          in   1          async, active-high reset
//  start        in   1          1-cycle pulse; starts a layer when idle
//  busy         out  1          high from start accepted until done
//  done         out  1          1-cycle pulse after the last write
//  fm_rd_en     out  1          FM read strobe
//  fm_rd_addr   out  ADDR_W     FM read address; data is returned 1 cycle later
//  fm_rd_data   in   DATA_W     FM read data
//  pool_en      out  1          1-cycle fire strobe to max_pool en
//  pool_win     out  9*DATA_W   slot k at [k*DATA_W +: DATA_W]; k=0 maps to num1, row-major
//  pool_ready   in   1          max_pool write_ready
//  pool_out     in   DATA_W     max_pool out
//  out_wr_en    out  1          output buffer write strobe
//  out_wr_addr  out  ADDR_W     output buffer address
//  out_wr_data  out  DATA_W     pooled value
// BEHAVIOUR
//  Reset: every output is 0, FSM=IDLE, all counters are 0. Reset mid-layer aborts immediately; no further write, no done.
//  FSM states: IDLE -> FETCH -> CAPT -> FIRE -> WAIT -> WRITE -> (FETCH | DONE) -> IDLE.
//  - IDLE: start=1 moves to FETCH and sets busy. Start while busy is ignored.
//  - FETCH: issues one read per cycle, kx inner, ky outer.
//    Address = ch*IN_H*IN_W + (oy*STRIDE+ky)*IN_W + ox*STRIDE+kx.
//    Read data lands in its window slot 1 cycle later.
//  - CAPT: one cycle to capture the last read.
//  - FIRE: pool_en=1 for exactly 1 cycle. pool_win is held stable from FIRE until WRITE.
//  - WAIT: waits on pool_ready with no fixed latency assumed (max_pool responds 2 cycles after en). pool_out is registered when pool_ready=1.
//  - WRITE: out_wr_en=1 for 1 cycle.
//    out_wr_addr = ch*OUT_H*OUT_W + oy*OUT_W + ox.
//    Then advance ox, wrap to oy, wrap to ch.
//  - DONE: when the last (ch,oy,ox) has been written, done pulses and busy drops in the same cycle; next state is IDLE.
//  pool_ready outside WAIT is ignored. Each window gets exactly one write.
//  Counters are unsigned. Address math is ADDR_W wide; the integrator sizes ADDR_W to fit CHANNELS*IN_H*IN_W.
// CONFIGURATION
//  MAX_POOL_CTRL_COL_REUSE_EN
//  - Defined, and STRIDE<3: for ox>0, window columns kx>=STRIDE shift into columns kx-STRIDE. Only the 3*STRIDE new pixels are fetched (6 when STRIDE=2). At ox=0 the full 9 are fetched.
//  - Undefined: every window fetches all 9 pixels.
//  Results and write order are identical in both modes.
// STRUCTURE
//  max_pool_pkg: DATA_W default, WIN=9, K=3, state enum.
//  Sub-module max_pool_addr_gen: ch/oy/ox/ky/kx counters plus the rd/wr address arithmetic.
//  Top FSM, window register and handshake stay in max_pool_ctrl.
// TESTING
//  Bench: IN_W=IN_H=5, CHANNELS=2, STRIDE=2 (OUT 2x2), FM[a]=a, behavioural max_pool model.
//  1. start -> window 0 reads addrs 0,1,2,5,6,7,10,11,12; pool_win slots = those values. Expect write addr 0, data 12.
//  2. Full layer -> 8 writes at addrs 0..7 with data 12,14,22,24,37,39,47,49. done pulses once, 1 cycle after the last write.
//  3. MAX_POOL_CTRL_COL_REUSE_EN defined -> window (0,0,1) reads only 3,4,8,9,13,14; write data 14. Total reads 60 vs 72 without the macro.
//  4. start pulsed again while busy -> ignored; exactly 8 writes, one done.
//  5. rst asserted in WAIT of window 3 -> all outputs 0 the same cycle. A later pool_ready produces no write. A new start restarts from addr 0.
//  6. pool_ready delayed by 10 extra cycles -> FSM holds in WAIT, pool_win stable, write data still correct.

Source files
------------

// File: rtl/max_pool_pkg.sv
// Shared constants and the sequencer state type for the 3x3 max-pool controller.
// The optional column-reuse fetch mode is enabled by defining MAX_POOL_CTRL_COL_REUSE_EN.
package max_pool_pkg;

  localparam int DATA_W_DEF = 23;
  localparam int WIN        = 9;
  localparam int K          = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_FIRE  = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/max_pool_addr_gen.sv
// Window walker: ch/oy/ox window counters, ky/kx tap counters and the FM read /
// output write address arithmetic. kx restarts at kx_first so that a window
// reusing shifted columns only visits the new columns.
module max_pool_addr_gen
  import max_pool_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int IN_W     = 55,
  parameter int IN_H     = 55,
  parameter int CHANNELS = 96,
  parameter int STRIDE   = 2,
  parameter int OUT_W    = 27,
  parameter int OUT_H    = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              kx_step,
  input  logic              win_step,
  input  logic              reuse_next,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        slot,
  output logic              last_tap,
  output logic              ox_last,
  output logic              last_win
);

  localparam int CH_W = cnt_w(CHANNELS);
  localparam int OY_W = cnt_w(OUT_H);
  localparam int OX_W = cnt_w(OUT_W);

  logic [CH_W-1:0] ch_q;
  logic [OY_W-1:0] oy_q;
  logic [OX_W-1:0] ox_q;
  logic [1:0]      ky_q, kx_q, kx_first_q;
  logic [1:0]      kx_next_first;
  logic            oy_last, ch_last;

  assign kx_next_first = reuse_next ? 2'(K - STRIDE) : 2'd0;
  assign ox_last  = (ox_q == OX_W'(OUT_W - 1));
  assign oy_last  = (oy_q == OY_W'(OUT_H - 1));
  assign ch_last  = (ch_q == CH_W'(CHANNELS - 1));
  assign last_win = ch_last && oy_last && ox_last;
  assign last_tap = (ky_q == 2'd2) && (kx_q == 2'd2);
  assign slot     = {2'b00, ky_q} * 4'd3 + {2'b00, kx_q};

  assign rd_addr = ADDR_W'(ch_q) * ADDR_W'(IN_H * IN_W)
                 + (ADDR_W'(oy_q) * ADDR_W'(STRIDE) + ADDR_W'(ky_q)) * ADDR_W'(IN_W)
                 + ADDR_W'(ox_q) * ADDR_W'(STRIDE) + ADDR_W'(kx_q);
  assign wr_addr = ADDR_W'(ch_q) * ADDR_W'(OUT_H * OUT_W)
                 + ADDR_W'(oy_q) * ADDR_W'(OUT_W) + ADDR_W'(ox_q);

  // Tap counters step per read; window counters step per write (ox inner, ch outer).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      kx_first_q <= '0;
    end else if (clear) begin
      ch_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      kx_first_q <= '0;
    end else if (win_step) begin
      ky_q       <= '0;
      kx_q       <= kx_next_first;
      kx_first_q <= kx_next_first;
      if (ox_last) begin
        ox_q <= '0;
        if (oy_last) begin
          oy_q <= '0;
          ch_q <= ch_last ? '0 : ch_q + CH_W'(1);
        end else begin
          oy_q <= oy_q + OY_W'(1);
        end
      end else begin
        ox_q <= ox_q + OX_W'(1);
      end
    end else if (kx_step) begin
      if (kx_q == 2'd2) begin
        kx_q <= kx_first_q;
        ky_q <= (ky_q == 2'd2) ? 2'd0 : ky_q + 2'd1;
      end else begin
        kx_q <= kx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/max_pool_ctrl.sv
// Sequencer for the 3x3 max-pool datapath: fetches each window from the FM
// buffer, fires the pool unit, waits for its result and writes it out.
// Handshake: pool_en is a one-cycle fire; the result is taken in WAIT on the
// first cycle pool_ready=1, pool_ready is ignored in every other state.
// Define MAX_POOL_CTRL_COL_REUSE_EN to shift overlapping columns between
// horizontally adjacent windows instead of refetching them (STRIDE<3 only).
module max_pool_ctrl
  import max_pool_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = 20,
  parameter int IN_W     = 55,
  parameter int IN_H     = 55,
  parameter int CHANNELS = 96,
  parameter int STRIDE   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fm_rd_en,
  output logic [ADDR_W-1:0]     fm_rd_addr,
  input  logic [DATA_W-1:0]     fm_rd_data,
  output logic                  pool_en,
  output logic [WIN*DATA_W-1:0] pool_win,
  input  logic                  pool_ready,
  input  logic [DATA_W-1:0]     pool_out,
  output logic                  out_wr_en,
  output logic [ADDR_W-1:0]     out_wr_addr,
  output logic [DATA_W-1:0]     out_wr_data,
  output logic [2:0]            dbg_state
);

  localparam int OUT_W = (IN_W - K) / STRIDE + 1;
  localparam int OUT_H = (IN_H - K) / STRIDE + 1;
`ifdef MAX_POOL_CTRL_COL_REUSE_EN
  localparam bit COL_REUSE = (STRIDE < K);
`else
  localparam bit COL_REUSE = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   win_q [WIN];
  logic                rd_pend_q;
  logic [3:0]          rd_slot_q;
  logic [DATA_W-1:0]   res_q;
  logic                clear, kx_step, win_step, reuse_next;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic [3:0]          slot;
  logic                last_tap, ox_last, last_win;

  // The next window reuses columns only when it stays on the same output row.
  assign reuse_next = COL_REUSE && !ox_last;

  max_pool_addr_gen #(
    .ADDR_W(ADDR_W), .IN_W(IN_W), .IN_H(IN_H), .CHANNELS(CHANNELS),
    .STRIDE(STRIDE), .OUT_W(OUT_W), .OUT_H(OUT_H)
  ) u_addr_gen (
    .clk(clk), .rst(rst), .clear(clear), .kx_step(kx_step),
    .win_step(win_step), .reuse_next(reuse_next), .rd_addr(rd_addr),
    .wr_addr(wr_addr), .slot(slot), .last_tap(last_tap),
    .ox_last(ox_last), .last_win(last_win)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode; all outputs derive from the state so reset zeroes them at once.
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    kx_step   = 1'b0;
    win_step  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    fm_rd_en  = 1'b0;
    pool_en   = 1'b0;
    out_wr_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        fm_rd_en = 1'b1;
        kx_step  = 1'b1;
        if (last_tap) state_d = S_CAPT;
      end
      S_CAPT: begin
        busy    = 1'b1;
        state_d = S_FIRE;
      end
      S_FIRE: begin
        busy    = 1'b1;
        pool_en = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (pool_ready) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        out_wr_en = 1'b1;
        win_step  = 1'b1;
        state_d   = last_win ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fm_rd_addr  = fm_rd_en  ? rd_addr : '0;
  assign out_wr_addr = out_wr_en ? wr_addr : '0;
  assign out_wr_data = out_wr_en ? res_q   : '0;
  assign dbg_state   = state_q;

  // Remember which slot each outstanding read belongs to (data returns next cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_slot_q <= '0;
    end else begin
      rd_pend_q <= fm_rd_en;
      rd_slot_q <= slot;
    end
  end

  // Window register: capture returned pixels; after a write, slide kept columns left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
    end else if (rd_pend_q) begin
      win_q[rd_slot_q] <= fm_rd_data;
    end else if (out_wr_en && reuse_next) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - STRIDE; c++)
          win_q[r*K + c] <= win_q[r*K + c + STRIDE];
    end
  end

  // Pool result register, loaded on the accepting cycle of WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 res_q <= '0;
    else if (state_q == S_WAIT && pool_ready) res_q <= pool_out;
  end

  for (genvar k = 0; k < WIN; k++) begin : g_win
    assign pool_win[k*DATA_W +: DATA_W] = win_q[k];
  end

endmodule
